vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA timing + pixel generator; drop-in successor to the fixed 640x480@60 core.
//  Timing, sync polarity and colour depth are parameters; built-in test patterns are selectable at runtime.
//  Sits between the pixel clock domain and the DAC/resistor ladder; feeds X/Y to an upstream pixel source.
// PARAMETERS
//  H_VISIBLE 640 visible px/line | H_FRONT 16 | H_SYNC 96 | H_BACK 48   (H_TOTAL = sum = 800)
//  V_VISIBLE 480 visible lines   | V_FRONT 10 | V_SYNC 2  | V_BACK 33   (V_TOTAL = sum = 525)
//  HSYNC_POL 0  active level of HSync_o (0 = active low)
//  VSYNC_POL 0  active level of VSync_o (0 = active low)
//  COLOR_BITS 4 bits per colour channel
// PORTS
//  Clock        in  1          pixel clock (25.175 MHz for defaults)
//  Reset        in  1          asynchronous, active-low reset
//  Mode_i       in  2          0 external, 1 colour bars, 2 checkerboard, 3 grey gradient
//  Red_i/Green_i/Blue_i in COLOR_BITS  external pixel for the current X_o/Y_o (mode 0 only)
//  X_o          out HW         horizontal counter, HW = $clog2(H_TOTAL)
//  Y_o          out VW         vertical counter, VW = $clog2(V_TOTAL)
//  Active_o     out 1          X_o < H_VISIBLE && Y_o < V_VISIBLE (combinational from counters)
//  FrameStart_o out 1          1-cycle pulse when counters == (0,0)
//  HSync_o/VSync_o out 1       registered syncs, aligned with RGB
//  Red_o/Green_o/Blue_o out COLOR_BITS  registered colour
// BEHAVIOUR
//  - Reset low: X=Y=0, syncs at inactive level (~POL), RGB=0, latched mode=0. Counting resumes at (0,0) on the first edge after release.
//  - X increments every clock; X==H_TOTAL-1 -> X=0 and Y+1; Y==V_TOTAL-1 on that wrap -> Y=0.
//  - HSync active for X in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (defaults 656..751).
//  - VSync active for Y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (defaults 490..491).
//  - Latency: X_o/Y_o/Active_o/FrameStart_o describe cycle N; Red_i..Blue_i are sampled in cycle N.
//    HSync_o/VSync_o/RGB for that pixel appear registered at N+1, mutually aligned.
//  - RGB forced to 0 when !Active, regardless of mode or inputs.
//  - Mode_i is latched only in the cycle FrameStart_o=1. A mid-frame change takes effect on the next frame.
//  - Mode 1: 8 bars, width H_VISIBLE/8 (H_VISIBLE % 8 == 0 is required); order white, yellow, cyan, green,
//    magenta, red, blue, black. Full-scale channel = all ones.
//  - Mode 2: white when X[5]^Y[5], otherwise black (32-px squares).
//  - Mode 3: R=G=B=(X>>3) truncated to COLOR_BITS LSBs.
//  - Simultaneous H and V wrap: a single-cycle transition to (0,0); FrameStart_o asserts there.
// CONFIGURATION
//  VGA_BORDER_EN defined: on X==0, X==H_VISIBLE-1, Y==0 or Y==V_VISIBLE-1 (while Active), RGB is all ones,
//    overriding every mode.
//  Not defined: no override; pattern/external pixel is shown unchanged at the edges.
// STRUCTURE
//  vga_pkg: mode enum (MODE_EXT, MODE_BARS, MODE_CHECK, MODE_GRAD), 3-bit bar colour table, default timing constants.
//  Sub-module vga_pattern: combinational (mode, X, Y, ext RGB) -> RGB. Counters, syncs and output regs stay in the top.
// TESTING
//  1 Defaults, reset low 10 clk -> HSync_o=VSync_o=1, RGB=0; release -> X_o=0,Y_o=0, FrameStart_o=1 on first cycle.
//  2 Free run one frame -> HSync_o low exactly 96 clk starting one cycle after X_o==656; VSync_o low on lines 490-491; frame=420000 clk.
//  3 Mode_i=1 at frame start -> at X=0..79 RGB=F,F,F; X=80 RGB=F,F,0; X=560..639 RGB=0; X>=640 RGB=0.
//  4 Mode_i 0->2 at Y=100 -> external pixels continue until wrap; checkerboard visible from next FrameStart.
//  5 HSYNC_POL=1, VSYNC_POL=1, reset -> syncs idle 0, pulse high; with VGA_BORDER_EN, mode 0 input 0 -> row 0 and column 639 all ones.
//  6 Reset asserted at Y=300 -> outputs at reset values immediately (async); after release, restart at (0,0) with mode 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing generator: mode encoding,
// default 640x480@60 timing and the colour-bar table.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_t;

  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_COLOR_BITS = 4;

  // {R,G,B} on/off per bar, left to right
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111; // white
      3'd1:    c = 3'b110; // yellow
      3'd2:    c = 3'b011; // cyan
      3'd3:    c = 3'b010; // green
      3'd4:    c = 3'b101; // magenta
      3'd5:    c = 3'b100; // red
      3'd6:    c = 3'b001; // blue
      default: c = 3'b000; // black
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern.sv
// Combinational pixel source: picks external RGB or a test pattern for (x,y),
// blanks outside the visible area. VGA_BORDER_EN adds a full-white frame border.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int HW         = 10,
  parameter int VW         = 10
) (
  input  mode_t                 mode,
  input  logic [HW-1:0]         x,
  input  logic [VW-1:0]         y,
  input  logic [COLOR_BITS-1:0] ext_r,
  input  logic [COLOR_BITS-1:0] ext_g,
  input  logic [COLOR_BITS-1:0] ext_b,
  output logic                  active,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue
);

  localparam int BAR_W = H_VISIBLE / 8;
  localparam logic [COLOR_BITS-1:0] FULL = '1;

  logic [HW-1:0]         bar_pos;
  logic [2:0]            bar_idx;
  logic [2:0]            bar_c;
  logic [COLOR_BITS-1:0] grad;
  logic                  border;

  assign active = (x < HW'(H_VISIBLE)) && (y < VW'(V_VISIBLE));

`ifdef VGA_BORDER_EN
  assign border = (x == '0) || (x == HW'(H_VISIBLE - 1)) ||
                  (y == '0) || (y == VW'(V_VISIBLE - 1));
`else
  assign border = 1'b0;
`endif

  always_comb begin
    bar_pos = x / HW'(BAR_W);
    // clamp only matters in blanking, where the output is zeroed anyway
    bar_idx = (bar_pos > HW'(7)) ? 3'd7 : bar_pos[2:0];
    bar_c   = bar_rgb(bar_idx);
    grad    = COLOR_BITS'(x >> 3);
  end

  always_comb begin
    red   = '0;
    green = '0;
    blue  = '0;
    if (active) begin
      if (border) begin
        {red, green, blue} = {3{FULL}};
      end else begin
        case (mode)
          MODE_EXT: begin
            red   = ext_r;
            green = ext_g;
            blue  = ext_b;
          end
          MODE_BARS: begin
            red   = {COLOR_BITS{bar_c[2]}};
            green = {COLOR_BITS{bar_c[1]}};
            blue  = {COLOR_BITS{bar_c[0]}};
          end
          MODE_CHECK: begin
            if (x[5] ^ y[5]) {red, green, blue} = {3{FULL}};
          end
          MODE_GRAD: begin
            red   = grad;
            green = grad;
            blue  = grad;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: X/Y counters, sync generation, frame-latched
// pattern mode and a registered RGB/sync output stage. Optional VGA_BORDER_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [1:0]            Mode_i,
  input  logic [COLOR_BITS-1:0] Red_i,
  input  logic [COLOR_BITS-1:0] Green_i,
  input  logic [COLOR_BITS-1:0] Blue_i,
  output logic [HW-1:0]         X_o,
  output logic [VW-1:0]         Y_o,
  output logic                  Active_o,
  output logic                  FrameStart_o,
  output logic                  HSync_o,
  output logic                  VSync_o,
  output logic [COLOR_BITS-1:0] Red_o,
  output logic [COLOR_BITS-1:0] Green_o,
  output logic [COLOR_BITS-1:0] Blue_o
);

  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [HW-1:0]         x;
  logic [VW-1:0]         y;
  logic                  h_last;
  logic                  v_last;
  logic                  frame_start;
  logic                  hs_on;
  logic                  vs_on;
  logic                  active;
  mode_t                 mode_q;
  mode_t                 mode_cur;
  logic [COLOR_BITS-1:0] pat_r;
  logic [COLOR_BITS-1:0] pat_g;
  logic [COLOR_BITS-1:0] pat_b;

  assign h_last      = (x == HW'(H_TOTAL - 1));
  assign v_last      = (y == VW'(V_TOTAL - 1));
  assign frame_start = (x == '0) && (y == '0);
  assign hs_on       = (x >= HW'(HS_START)) && (x <= HW'(HS_END));
  assign vs_on       = (y >= VW'(VS_START)) && (y <= VW'(VS_END));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      x <= '0;
      y <= '0;
    end else if (h_last) begin
      x <= '0;
      y <= v_last ? '0 : y + VW'(1);
    end else begin
      x <= x + HW'(1);
    end
  end

  // The (0,0) pixel already uses the newly requested mode; the register holds
  // it for the rest of the frame so mid-frame changes wait for the next frame.
  assign mode_cur = frame_start ? mode_t'(Mode_i) : mode_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)           mode_q <= MODE_EXT;
    else if (frame_start) mode_q <= mode_t'(Mode_i);
  end

  vga_pattern #(
    .H_VISIBLE  (H_VISIBLE),
    .V_VISIBLE  (V_VISIBLE),
    .COLOR_BITS (COLOR_BITS),
    .HW         (HW),
    .VW         (VW)
  ) u_pattern (
    .mode   (mode_cur),
    .x      (x),
    .y      (y),
    .ext_r  (Red_i),
    .ext_g  (Green_i),
    .ext_b  (Blue_i),
    .active (active),
    .red    (pat_r),
    .green  (pat_g),
    .blue   (pat_b)
  );

  // Syncs share the RGB register stage so all five leave on the same edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      HSync_o <= ~HSYNC_POL;
      VSync_o <= ~VSYNC_POL;
      Red_o   <= '0;
      Green_o <= '0;
      Blue_o  <= '0;
    end else begin
      HSync_o <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      VSync_o <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      Red_o   <= pat_r;
      Green_o <= pat_g;
      Blue_o  <= pat_b;
    end
  end

  assign X_o          = x;
  assign Y_o          = y;
  assign Active_o     = active;
  assign FrameStart_o = frame_start;

endmodule
